// File: rtl/jzjpcc_memory_access_if.sv
// Memory-to-writeback stage bundle: registered destination metadata, raw load word and the
// lane information the writeback load formatter needs to extract bytes/halves.
interface jzjpcc_writeback_if;
  logic [4:0]  rdAddr;
  logic        rdWriteEnable;
  logic        rdSource;
  logic [31:0] memoryOut;
  logic [31:0] aluResult;
  logic [2:0]  funct3;
  logic [3:0]  memByteMask;

  modport memory (
    output rdAddr, rdWriteEnable, rdSource, memoryOut, aluResult, funct3, memByteMask
  );
  modport writeback (
    input rdAddr, rdWriteEnable, rdSource, memoryOut, aluResult, funct3, memByteMask
  );
endinterface

// File: rtl/jzjpcc_memory_access.sv
// Memory-stage load/store unit: maps execute results onto big-endian bus lanes, stalls until
// the bus acknowledges, and registers the writeback-stage view of each instruction.
module jzjpcc_memory_access (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inValid,
  input  logic [4:0]  inRdAddr,
  input  logic        inRdWriteEnable,
  input  logic        inRdSource,
  input  logic [31:0] inAluResult,
  input  logic [31:0] inRs2,
  input  logic [2:0]  inFunct3,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  output logic        stall,
  output logic        misaligned,
  output logic        busRequest,
  output logic        busWrite,
  output logic [29:0] busWordAddr,
  output logic [3:0]  busByteMask,
  output logic [31:0] busWriteData,
  input  logic [31:0] busReadData,
  input  logic        busAck,
  jzjpcc_writeback_if.memory writebackIF
);
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [29:0] req_addr_q, req_addr_d;
  logic [3:0]  req_mask_q, req_mask_d;
  logic [31:0] req_data_q, req_data_d;
  logic        req_write_q, req_write_d;
  logic [4:0]  m_rd_addr_q, m_rd_addr_d;
  logic        m_rd_we_q, m_rd_we_d;
  logic        m_rd_src_q, m_rd_src_d;
  logic [31:0] m_alu_q, m_alu_d;
  logic [2:0]  m_funct3_q, m_funct3_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        wb_rd_we_q, wb_rd_we_d;
  logic        wb_rd_src_q, wb_rd_src_d;
  logic [31:0] wb_mem_out_q, wb_mem_out_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [2:0]  wb_funct3_q, wb_funct3_d;
  logic [3:0]  wb_mask_q, wb_mask_d;
  logic        misaligned_q, misaligned_d;

  logic [1:0]  offset;
  logic        is_mem, aligned, issue;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;

  // Lane 0 of the bus is bits [31:24], so store data is byte-swapped relative to inRs2.
  always_comb begin
    offset    = inAluResult[1:0];
    is_mem    = inMemRead | inMemWrite;
    aligned   = 1'b0;
    lane_mask = 4'b0000;
    lane_data = 32'h0;
    case (inFunct3[1:0])
      2'b00: begin
        aligned   = 1'b1;
        lane_mask = 4'b1000 >> offset;
        lane_data = {4{inRs2[7:0]}};
      end
      2'b01: begin
        aligned   = ~offset[0];
        lane_mask = offset[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{inRs2[7:0], inRs2[15:8]}};
      end
      2'b10: begin
        aligned   = (offset == 2'b00);
        lane_mask = 4'b1111;
        lane_data = {inRs2[7:0], inRs2[15:8], inRs2[23:16], inRs2[31:24]};
      end
      default: ;
    endcase
    issue = (state_q == IDLE) & inValid & is_mem & aligned;
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_mask_d   = req_mask_q;
    req_data_d   = req_data_q;
    req_write_d  = req_write_q;
    m_rd_addr_d  = m_rd_addr_q;
    m_rd_we_d    = m_rd_we_q;
    m_rd_src_d   = m_rd_src_q;
    m_alu_d      = m_alu_q;
    m_funct3_d   = m_funct3_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_we_d   = 1'b0;
    wb_rd_src_d  = wb_rd_src_q;
    wb_mem_out_d = wb_mem_out_q;
    wb_alu_d     = wb_alu_q;
    wb_funct3_d  = wb_funct3_q;
    wb_mask_d    = wb_mask_q;
    misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (inValid && !is_mem) begin
          wb_rd_addr_d = inRdAddr;
          wb_rd_we_d   = inRdWriteEnable;
          wb_rd_src_d  = inRdSource;
          wb_alu_d     = inAluResult;
          wb_funct3_d  = inFunct3;
          wb_mask_d    = 4'b0000;
        end else if (inValid && !aligned) begin
          misaligned_d = 1'b1;
        end else if (issue) begin
          state_d     = ACCESS;
          req_addr_d  = inAluResult[31:2];
          req_mask_d  = lane_mask;
          req_data_d  = lane_data;
          req_write_d = inMemWrite;
          m_rd_addr_d = inRdAddr;
          m_rd_we_d   = inRdWriteEnable;
          m_rd_src_d  = inRdSource;
          m_alu_d     = inAluResult;
          m_funct3_d  = inFunct3;
        end
      end
      ACCESS: begin
        // The instruction is still presented during the ack cycle; it is retired from the
        // latched copy and the return to IDLE keeps it from being issued a second time.
        if (busAck) begin
          state_d      = IDLE;
          wb_rd_addr_d = m_rd_addr_q;
          wb_rd_we_d   = m_rd_we_q;
          wb_rd_src_d  = m_rd_src_q;
          wb_alu_d     = m_alu_q;
          wb_funct3_d  = m_funct3_q;
          wb_mask_d    = req_mask_q;
          if (!req_write_q) wb_mem_out_d = busReadData;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_mask_q   <= '0;
      req_data_q   <= '0;
      req_write_q  <= 1'b0;
      m_rd_addr_q  <= '0;
      m_rd_we_q    <= 1'b0;
      m_rd_src_q   <= 1'b0;
      m_alu_q      <= '0;
      m_funct3_q   <= '0;
      wb_rd_addr_q <= '0;
      wb_rd_we_q   <= 1'b0;
      wb_rd_src_q  <= 1'b0;
      wb_mem_out_q <= '0;
      wb_alu_q     <= '0;
      wb_funct3_q  <= '0;
      wb_mask_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_mask_q   <= req_mask_d;
      req_data_q   <= req_data_d;
      req_write_q  <= req_write_d;
      m_rd_addr_q  <= m_rd_addr_d;
      m_rd_we_q    <= m_rd_we_d;
      m_rd_src_q   <= m_rd_src_d;
      m_alu_q      <= m_alu_d;
      m_funct3_q   <= m_funct3_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_we_q   <= wb_rd_we_d;
      wb_rd_src_q  <= wb_rd_src_d;
      wb_mem_out_q <= wb_mem_out_d;
      wb_alu_q     <= wb_alu_d;
      wb_funct3_q  <= wb_funct3_d;
      wb_mask_q    <= wb_mask_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Gating with reset_n keeps the pipeline unstalled while reset is held.
  assign stall        = reset_n & (issue | ((state_q == ACCESS) & ~busAck));
  assign misaligned   = misaligned_q;
  assign busRequest   = (state_q == ACCESS);
  assign busWrite     = req_write_q;
  assign busWordAddr  = req_addr_q;
  assign busByteMask  = req_mask_q;
  assign busWriteData = req_data_q;

  assign writebackIF.rdAddr        = wb_rd_addr_q;
  assign writebackIF.rdWriteEnable = wb_rd_we_q;
  assign writebackIF.rdSource      = wb_rd_src_q;
  assign writebackIF.memoryOut     = wb_mem_out_q;
  assign writebackIF.aluResult     = wb_alu_q;
  assign writebackIF.funct3        = wb_funct3_q;
  assign writebackIF.memByteMask   = wb_mask_q;
endmodule

// File: tb/tb_jzjpcc_memory_access.sv
// Directed and randomized checks of the memory-access stage against a transaction-level
// model of lane mapping, stall timing and writeback contents.
module tb_jzjpcc_memory_access;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_rd_we, in_rd_src, in_mem_read, in_mem_write;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_alu, in_rs2, bus_rdata;
  logic [2:0]  in_funct3;
  logic        stall, misaligned, bus_req, bus_write, bus_ack;
  logic [29:0] bus_addr;
  logic [3:0]  bus_mask;
  logic [31:0] bus_wdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_mem_out = 32'h0;

  jzjpcc_writeback_if wb_if ();

  jzjpcc_memory_access dut (
    .clock(clock), .reset_n(reset_n), .inValid(in_valid),
    .inRdAddr(in_rd_addr), .inRdWriteEnable(in_rd_we), .inRdSource(in_rd_src),
    .inAluResult(in_alu), .inRs2(in_rs2), .inFunct3(in_funct3),
    .inMemRead(in_mem_read), .inMemWrite(in_mem_write),
    .stall(stall), .misaligned(misaligned), .busRequest(bus_req), .busWrite(bus_write),
    .busWordAddr(bus_addr), .busByteMask(bus_mask), .busWriteData(bus_wdata),
    .busReadData(bus_rdata), .busAck(bus_ack), .writebackIF(wb_if)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Idle cycle: no valid instruction, optionally with a stray ack that must be ignored.
  task automatic do_idle(input logic stray_ack);
    in_valid = 1'b0;
    bus_ack  = stray_ack;
    #1;
    check_val("idle_stall", {31'b0, stall}, 32'd0);
    next_cycle();
    bus_ack = 1'b0;
    check_val("idle_busreq", {31'b0, bus_req}, 32'd0);
    check_val("idle_wb_we", {31'b0, wb_if.rdWriteEnable}, 32'd0);
    check_val("idle_wb_memout", wb_if.memoryOut, exp_mem_out);
  endtask

  // Presents one instruction right after a rising edge and follows it to writeback.
  task automatic do_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic [4:0] rd, input logic we,
                       input logic src, input int waits, input logic [31:0] rdata);
    logic [1:0]  off;
    logic        mem, ok;
    logic [3:0]  m;
    logic [31:0] d;
    off = alu[1:0];
    mem = mr | mw;
    m   = 4'b1000;
    case (f3[1:0])
      2'b00: begin ok = 1'b1; m = m >> off; d = {4{rs2[7:0]}}; end
      2'b01: begin ok = (off % 2 == 0); m = (off == 2'd2) ? 4'b0011 : 4'b1100;
                   d = {2{rs2[7:0], rs2[15:8]}}; end
      default: begin ok = (off == 2'd0); m = 4'b1111;
                     d = {rs2[7:0], rs2[15:8], rs2[23:16], rs2[31:24]}; end
    endcase
    in_valid = 1'b1; in_alu = alu; in_rs2 = rs2; in_funct3 = f3;
    in_mem_read = mr; in_mem_write = mw; in_rd_addr = rd; in_rd_we = we; in_rd_src = src;
    #1;
    check_val("stall_c0", {31'b0, stall}, {31'b0, mem & ok});
    next_cycle();
    if (!mem) begin
      check_val("alu_misaligned", {31'b0, misaligned}, 32'd0);
      check_val("alu_busreq", {31'b0, bus_req}, 32'd0);
      check_val("alu_wb_rd", {27'b0, wb_if.rdAddr}, {27'b0, rd});
      check_val("alu_wb_we", {31'b0, wb_if.rdWriteEnable}, {31'b0, we});
      check_val("alu_wb_src", {31'b0, wb_if.rdSource}, {31'b0, src});
      check_val("alu_wb_alu", wb_if.aluResult, alu);
      check_val("alu_wb_f3", {29'b0, wb_if.funct3}, {29'b0, f3});
      check_val("alu_wb_memout", wb_if.memoryOut, exp_mem_out);
      $display("op alu %08h rd=%0d we=%0b", alu, rd, we);
    end else if (!ok) begin
      check_val("mis_pulse", {31'b0, misaligned}, 32'd1);
      check_val("mis_busreq", {31'b0, bus_req}, 32'd0);
      check_val("mis_wb_we", {31'b0, wb_if.rdWriteEnable}, 32'd0);
      $display("op misaligned %s f3=%0d addr=%08h", mw ? "store" : "load", f3, alu);
    end else begin
      check_val("mem_busreq", {31'b0, bus_req}, 32'd1);
      check_val("mem_misaligned", {31'b0, misaligned}, 32'd0);
      check_val("mem_buswrite", {31'b0, bus_write}, {31'b0, mw});
      check_val("mem_busaddr", {2'b0, bus_addr}, {2'b0, alu[31:2]});
      check_val("mem_busmask", {28'b0, bus_mask}, {28'b0, m});
      check_val("mem_buswdata", bus_wdata, d);
      check_val("mem_wb_bubble", {31'b0, wb_if.rdWriteEnable}, 32'd0);
      for (int i = 0; i < waits; i++) begin
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        #1;
        check_val("wait_stall", {31'b0, stall}, 32'd1);
        next_cycle();
        check_val("wait_busreq", {31'b0, bus_req}, 32'd1);
        check_val("wait_busmask", {28'b0, bus_mask}, {28'b0, m});
        check_val("wait_wb_bubble", {31'b0, wb_if.rdWriteEnable}, 32'd0);
      end
      bus_ack = 1'b1;
      bus_rdata = rdata;
      #1;
      check_val("ack_stall", {31'b0, stall}, 32'd0);
      next_cycle();
      bus_ack = 1'b0;
      if (mr) exp_mem_out = rdata;
      check_val("done_busreq", {31'b0, bus_req}, 32'd0);
      check_val("done_wb_rd", {27'b0, wb_if.rdAddr}, {27'b0, rd});
      check_val("done_wb_we", {31'b0, wb_if.rdWriteEnable}, {31'b0, we});
      check_val("done_wb_src", {31'b0, wb_if.rdSource}, {31'b0, src});
      check_val("done_wb_alu", wb_if.aluResult, alu);
      check_val("done_wb_f3", {29'b0, wb_if.funct3}, {29'b0, f3});
      check_val("done_wb_mask", {28'b0, wb_if.memByteMask}, {28'b0, m});
      check_val("done_wb_memout", wb_if.memoryOut, exp_mem_out);
      $display("op %s f3=%0d addr=%08h waits=%0d mask=%04b", mw ? "store" : "load", f3, alu,
               waits, m);
    end
  endtask

  initial begin
    logic [2:0] load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    reset_n = 1'b0; in_valid = 1'b0; in_rd_addr = '0; in_rd_we = 1'b0; in_rd_src = 1'b0;
    in_alu = '0; in_rs2 = '0; in_funct3 = '0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0;
    #3;
    check_val("rst_stall", {31'b0, stall}, 32'd0);
    check_val("rst_busreq", {31'b0, bus_req}, 32'd0);
    check_val("rst_bus", {bus_write, bus_addr, 1'b0}, 32'd0);
    check_val("rst_busmask", {28'b0, bus_mask}, 32'd0);
    check_val("rst_buswdata", bus_wdata, 32'd0);
    check_val("rst_misaligned", {31'b0, misaligned}, 32'd0);
    check_val("rst_wb_meta", {wb_if.rdAddr, wb_if.rdWriteEnable, wb_if.rdSource,
                              wb_if.funct3, wb_if.memByteMask}, 32'd0);
    check_val("rst_wb_memout", wb_if.memoryOut, 32'd0);
    check_val("rst_wb_alu", wb_if.aluResult, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();

    do_op(32'h12345678, 32'h0, 3'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 0, 32'h0);
    do_op(32'h00001002, 32'h000000AB, 3'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 3, 32'h0);
    do_op(32'h00002000, 32'h11223344, 3'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1, 32'h0);
    do_op(32'h00003002, 32'h0, 3'd1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 0, 32'hAAAA3412);
    do_op(32'h00000001, 32'h0, 3'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 0, 32'h0);
    do_idle(1'b1);
    check_val("mis_pulse_end", {31'b0, misaligned}, 32'd0);

    // Reset while a store is outstanding, with the instruction still presented.
    in_valid = 1'b1; in_alu = 32'h00004000; in_rs2 = 32'hCAFEF00D; in_funct3 = 3'd2;
    in_mem_read = 1'b0; in_mem_write = 1'b1; in_rd_we = 1'b0;
    next_cycle();
    check_val("rst_mid_busreq_pre", {31'b0, bus_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_mid_busreq", {31'b0, bus_req}, 32'd0);
    check_val("rst_mid_stall", {31'b0, stall}, 32'd0);
    check_val("rst_mid_wb_we", {31'b0, wb_if.rdWriteEnable}, 32'd0);
    exp_mem_out = 32'h0;
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    next_cycle();
    check_val("rst_mid_after", {31'b0, bus_req}, 32'd0);
    do_op(32'h00005003, 32'h0, 3'd4, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 2, 32'h01020304);
    $display("op reset mid-access recovered");

    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0, 1'b0,
                 5'($urandom), 1'($urandom), 1'($urandom), 0, 32'h0);
        1: do_op($urandom, $urandom, load_f3[$urandom_range(0, 4)], 1'b1, 1'b0,
                 5'($urandom), 1'($urandom), 1'b1, $urandom_range(0, 3), $urandom);
        2: do_op($urandom, $urandom, 3'($urandom_range(0, 2)), 1'b0, 1'b1,
                 5'($urandom), 1'b0, 1'b0, $urandom_range(0, 3), $urandom);
        default: begin
          do_idle(1'($urandom));
          $display("op idle");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
